// File: rtl/dmem_pkg.sv
// Shared state encoding and default bus widths for the data-RAM master.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dram_master.sv
// CPU-side request/response master driving a single-port data RAM with
// configurable read latency and an out-of-range error response.
module dram_master
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MEM_DEPTH = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_not_write,
    output logic              cs
);

    localparam logic [2:0]      LAT   = 3'(RD_LAT);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       we_q;
    logic       in_range;

    assign in_range  = {1'b0, req_addr} < DEPTH;
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = in_range ? ACCESS : RESP;
            ACCESS:  state_nxt = (we_q || LAT == 3'd0) ? RESP : WAIT;
            WAIT:    if (cnt == LAT) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM strobes are launched at the accept edge so they appear registered
    // during ACCESS; address/write_data double as the request latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs             <= 1'b0;
            read_not_write <= 1'b1;
            address        <= '0;
            write_data     <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            cnt            <= '0;
            we_q           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q <= req_we;
                        if (in_range) begin
                            cs             <= 1'b1;
                            address        <= req_addr;
                            read_not_write <= ~req_we;
                            if (req_we) write_data <= req_wdata;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    cs             <= 1'b0;
                    read_not_write <= 1'b1;
                    if (we_q) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else if (LAT == 3'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= read_data;
                    end else begin
                        cnt <= 3'd1;
                    end
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= read_data;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_master.sv
// Scoreboard bench for dram_master: one RD_LAT=1/MEM_DEPTH=1536 instance plus
// RD_LAT=0 and RD_LAT=3 instances for latency checks, each with a RAM model.
module tb_dram_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        req_we;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_ready;

    // main instance
    logic        rv_m, ready_m, rvld_m, err_m, rnw_m, cs_m;
    logic [15:0] rdata_m, wd_m, rd_m;
    logic [10:0] addr_m;
    // latency-sweep instances
    logic        rv0, ready0, rvld0, err0, rnw0, cs0;
    logic [15:0] rdata0, wd0, rd0;
    logic [10:0] addr0;
    logic        rv3, ready3, rvld3, err3, rnw3, cs3;
    logic [15:0] rdata3, wd3, rd3;
    logic [10:0] addr3;

    dram_master #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1), .MEM_DEPTH(1536)) u_main (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_m), .req_ready(ready_m),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvld_m), .resp_ready(resp_ready), .resp_rdata(rdata_m),
        .resp_err(err_m), .address(addr_m), .write_data(wd_m),
        .read_data(rd_m), .read_not_write(rnw_m), .cs(cs_m)
    );

    dram_master #(.ADDR_W(11), .DATA_W(16), .RD_LAT(0), .MEM_DEPTH(2048)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvld0), .resp_ready(resp_ready), .resp_rdata(rdata0),
        .resp_err(err0), .address(addr0), .write_data(wd0),
        .read_data(rd0), .read_not_write(rnw0), .cs(cs0)
    );

    dram_master #(.ADDR_W(11), .DATA_W(16), .RD_LAT(3), .MEM_DEPTH(2048)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvld3), .resp_ready(resp_ready), .resp_rdata(rdata3),
        .resp_err(err3), .address(addr3), .write_data(wd3),
        .read_data(rd3), .read_not_write(rnw3), .cs(cs3)
    );

    // RAM models: preload a few words while in reset
    logic [15:0] mem_m [0:2047];
    logic [15:0] mem0  [0:2047];
    logic [15:0] mem3  [0:2047];
    logic [15:0] p1, p2, p3;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_m[20]   <= 16'h1234;
            mem_m[1535] <= 16'hBEEF;
        end else if (cs_m && !rnw_m) begin
            mem_m[addr_m] <= wd_m;
        end
        rd_m <= mem_m[addr_m];
    end

    assign rd0 = mem0[addr0];
    always @(posedge clk) begin
        if (!rst_n) mem0[100] <= 16'h0C0C;
        else if (cs0 && !rnw0) mem0[addr0] <= wd0;
    end

    assign rd3 = p3;
    always @(posedge clk) begin
        if (!rst_n) mem3[100] <= 16'h3C3C;
        else if (cs3 && !rnw3) mem3[addr3] <= wd3;
        p1 <= mem3[addr3];
        p2 <= p1;
        p3 <= p2;
    end

    logic        sel3;
    logic        sel_valid, sel_ready, sel_err;
    logic [15:0] sel_rdata;
    assign sel_valid = sel3 ? rvld3  : rvld0;
    assign sel_ready = sel3 ? ready3 : ready0;
    assign sel_err   = sel3 ? err3   : err0;
    assign sel_rdata = sel3 ? rdata3 : rdata0;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cs_count = 0;
    int unsigned accepts = 0;
    int unsigned overlaps = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns one negedge after the accept edge.
    task automatic issue(input logic we, input logic [10:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_d, input logic exp_e,
                         input int unsigned lat, input bit hold);
        exp_t e;
        int unsigned n;
        req_we = we; req_addr = a; req_wdata = wd; rv_m = 1'b1;
        n = 0;
        while (!ready_m && n < 50) begin @(negedge clk); n++; end
        if (!ready_m) begin
            checks++; failures++;
            $display("FAIL accept_timeout addr=%0d actual=no_accept required=accept", a);
            rv_m = 1'b0;
            return;
        end
        e.rdata = exp_d; e.err = exp_e; e.due = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) rv_m = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic sweep(input bit use3, input int unsigned exp_lat, input logic [15:0] exp_d);
        int unsigned a;
        int unsigned n = 0;
        sel3 = use3;
        req_we = 1'b0; req_addr = 11'd100;
        check(use3 ? "lat3_ready" : "lat0_ready", sel_ready, 1);
        a = cyc;
        if (use3) rv3 = 1'b1; else rv0 = 1'b1;
        @(negedge clk);
        rv0 = 1'b0; rv3 = 1'b0;
        while (!sel_valid && n < 20) begin @(negedge clk); n++; end
        check(use3 ? "lat3_resp_cycle" : "lat0_resp_cycle", cyc - a, exp_lat);
        check(use3 ? "lat3_rdata" : "lat0_rdata", sel_rdata, exp_d);
        check(use3 ? "lat3_err" : "lat0_err", sel_err, 0);
        @(negedge clk);
    endtask

    // Monitor samples 2 time units after the negedge, clear of stimulus updates.
    initial begin : monitor
        exp_t e;
        bit first;
        bit idle_chk;
        first = 1'b1;
        idle_chk = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (cs_m) cs_count++;
            if (idle_chk) begin
                check("idle_after_handshake", ready_m, 1);
                idle_chk = 1'b0;
            end
            if (rst_n) begin
                if (rv_m && ready_m) accepts++;
                if (ready_m && rvld_m) overlaps++;
                if (rvld_m) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_resp actual=resp_valid required=no_resp rdata=0x%0h", rdata_m);
                    end else begin
                        e = sb[0];
                        if (first) begin
                            check("resp_cycle", cyc, e.due);
                            first = 1'b0;
                        end
                        check("resp_rdata", rdata_m, e.rdata);
                        check("resp_err", err_m, e.err);
                        if (resp_ready) begin
                            void'(sb.pop_front());
                            first = 1'b1;
                            idle_chk = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned n;
        rst_n = 1'b0; rv_m = 1'b0; rv0 = 1'b0; rv3 = 1'b0; sel3 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs", cs_m, 0);
        check("rst_rnw", rnw_m, 1);
        check("rst_address", addr_m, 0);
        check("rst_write_data", wd_m, 0);
        check("rst_resp_valid", rvld_m, 0);
        check("rst_resp_rdata", rdata_m, 0);
        check("rst_resp_err", err_m, 0);
        check("rst_req_ready", ready_m, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // write then read back, RD_LAT=1
        issue(1'b1, 11'd16, 16'h000A, 16'h0000, 1'b0, 2, 1'b0); drain();
        issue(1'b0, 11'd16, 16'h0000, 16'h000A, 1'b0, 3, 1'b0); drain();

        // backpressure: response held for 5 cycles
        resp_ready = 1'b0;
        issue(1'b0, 11'd20, 16'h0000, 16'h1234, 1'b0, 3, 1'b0);
        n = 0;
        while (!rvld_m && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        resp_ready = 1'b1;
        drain();

        // range boundary with MEM_DEPTH=1536
        issue(1'b0, 11'd1600, 16'h0000, 16'h0000, 1'b1, 1, 1'b0); drain();
        issue(1'b1, 11'd1536, 16'hDEAD, 16'h0000, 1'b1, 1, 1'b0); drain();
        issue(1'b0, 11'd1535, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b0); drain();

        // req_valid held high across back-to-back transactions
        issue(1'b1, 11'd5,    16'h5555, 16'h0000, 1'b0, 2, 1'b1);
        issue(1'b0, 11'd5,    16'h0000, 16'h5555, 1'b0, 3, 1'b1);
        issue(1'b1, 11'd6,    16'hA5A5, 16'h0000, 1'b0, 2, 1'b1);
        issue(1'b0, 11'd1600, 16'h0000, 16'h0000, 1'b1, 1, 1'b1);
        issue(1'b0, 11'd6,    16'h0000, 16'hA5A5, 1'b0, 3, 1'b0);
        drain();

        // reset while in WAIT: no response may follow
        req_we = 1'b0; req_addr = 11'd16; rv_m = 1'b1;
        @(negedge clk);
        rv_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("wait_rst_resp_valid", rvld_m, 0);
        check("wait_rst_cs", cs_m, 0);
        check("wait_rst_req_ready", ready_m, 1);
        repeat (6) @(negedge clk);

        issue(1'b0, 11'd16, 16'h0000, 16'h000A, 1'b0, 3, 1'b0); drain();

        // latency sweep
        sweep(1'b0, 2, 16'h0C0C);
        sweep(1'b1, 5, 16'h3C3C);

        repeat (2) @(negedge clk);
        check("cs_pulse_count", cs_count, 10);
        check("accept_count", accepts, 13);
        check("overlap_count", overlaps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
